// File: rtl/fb_pkg.sv
// Shared screen constants and the write-source state type for the frame manager sources.
package fb_pkg;

    localparam int unsigned DRAW_WIDTH        = 640;
    localparam int unsigned DRAW_HEIGHT       = 480;
    localparam int unsigned SCALE_DOWN_FACTOR = 2;
    localparam int unsigned COLOR_DEPTH       = 9;

    localparam int unsigned SCALE_SHIFT   = $clog2(SCALE_DOWN_FACTOR);
    localparam int unsigned SCALED_WIDTH  = DRAW_WIDTH >> SCALE_SHIFT;
    localparam int unsigned SCALED_HEIGHT = DRAW_HEIGHT >> SCALE_SHIFT;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRelease
    } src_state_e;

endpackage

// File: rtl/fb_rect_source_scanner.sv
// Loadable 2-D cell counter: walks cy0..cy1 (outer) and cx0..cx1 (inner), one cell per enable.
module fb_cell_scanner #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          load,
    input  logic          en,
    input  logic [XW-1:0] cx0,
    input  logic [XW-1:0] cx1,
    input  logic [YW-1:0] cy0,
    input  logic [YW-1:0] cy1,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          on_edge,
    output logic          last
);

    logic [XW-1:0] cx_q, cx_d, cx0_q, cx1_q;
    logic [YW-1:0] cy_q, cy_d, cy0_q, cy1_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (load) begin
            cx_d = cx0;
            cy_d = cy0;
        end else if (en) begin
            if (cx_q == cx1_q) begin
                cx_d = cx0_q;
                cy_d = cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cx_q  <= '0;
            cy_q  <= '0;
            cx0_q <= '0;
            cx1_q <= '0;
            cy0_q <= '0;
            cy1_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            if (load) begin
                cx0_q <= cx0;
                cx1_q <= cx1;
                cy0_q <= cy0;
                cy1_q <= cy1;
            end
        end
    end

    assign cx      = cx_q;
    assign cy      = cy_q;
    assign on_edge = (cx_q == cx0_q) || (cx_q == cx1_q) || (cy_q == cy0_q) || (cy_q == cy1_q);
    assign last    = (cx_q == cx1_q) && (cy_q == cy1_q);

endmodule

// File: rtl/fb_rect_source.sv
// Frame-manager write source that fills one rectangle (optionally bordered) on the scaled grid.
module fb_rect_source
    import fb_pkg::*;
#(
    parameter int unsigned SOURCE_ID         = 0,
    parameter int unsigned SEL_W             = 1,
    parameter int unsigned DRAW_WIDTH        = fb_pkg::DRAW_WIDTH,
    parameter int unsigned DRAW_HEIGHT       = fb_pkg::DRAW_HEIGHT,
    parameter int unsigned SCALE_DOWN_FACTOR = fb_pkg::SCALE_DOWN_FACTOR,
    parameter int unsigned COLOR_DEPTH       = fb_pkg::COLOR_DEPTH
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           write_awaited,
    input  logic [SEL_W-1:0]               write_source_sel,
    input  logic [$clog2(DRAW_WIDTH)-1:0]  rect_x,
    input  logic [$clog2(DRAW_HEIGHT)-1:0] rect_y,
    input  logic [$clog2(DRAW_WIDTH)-1:0]  rect_w,
    input  logic [$clog2(DRAW_HEIGHT)-1:0] rect_h,
    input  logic [COLOR_DEPTH-1:0]         fill_color,
    input  logic [COLOR_DEPTH-1:0]         border_color,
    input  logic                           border_en,
    output logic                           write_active,
    output logic [$clog2(DRAW_WIDTH)-1:0]  write_x_addr,
    output logic [$clog2(DRAW_HEIGHT)-1:0] write_y_addr,
    output logic [COLOR_DEPTH-1:0]         write_color_data,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned XW = $clog2(DRAW_WIDTH);
    localparam int unsigned YW = $clog2(DRAW_HEIGHT);
    localparam int unsigned S  = $clog2(SCALE_DOWN_FACTOR);
    localparam logic [XW:0] X_LAST = (XW+1)'(DRAW_WIDTH - 1);
    localparam logic [YW:0] Y_LAST = (YW+1)'(DRAW_HEIGHT - 1);

    src_state_e state_q, state_d;

    logic                   active_q, active_d, done_q, done_d, busy_q, busy_d;
    logic                   scan_end_q, scan_end_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [COLOR_DEPTH-1:0] color_q, color_d, fill_q, border_q;
    logic                   ben_q;

    logic          grant, load, en, on_edge, last;
    logic [XW-1:0] cx, ld_cx0, ld_cx1, w_eff;
    logic [YW-1:0] cy, ld_cy0, ld_cy1, h_eff;
    logic [XW:0]   x_sum, x_beg, x_end;
    logic [YW:0]   y_sum, y_beg, y_end;

    assign grant = write_awaited && (write_source_sel == SEL_W'(SOURCE_ID));

    // Bounds use one extra bit so x+w cannot wrap before clamping to the screen.
    always_comb begin
        w_eff  = (rect_w == '0) ? XW'(1) : rect_w;
        h_eff  = (rect_h == '0) ? YW'(1) : rect_h;
        x_sum  = {1'b0, rect_x} + {1'b0, w_eff} - 1'b1;
        y_sum  = {1'b0, rect_y} + {1'b0, h_eff} - 1'b1;
        x_end  = (x_sum > X_LAST) ? X_LAST : x_sum;
        y_end  = (y_sum > Y_LAST) ? Y_LAST : y_sum;
        x_beg  = ({1'b0, rect_x} > X_LAST) ? X_LAST : {1'b0, rect_x};
        y_beg  = ({1'b0, rect_y} > Y_LAST) ? Y_LAST : {1'b0, rect_y};
        ld_cx0 = XW'(x_beg >> S);
        ld_cx1 = XW'(x_end >> S);
        ld_cy0 = YW'(y_beg >> S);
        ld_cy1 = YW'(y_end >> S);
    end

    fb_cell_scanner #(
        .XW (XW),
        .YW (YW)
    ) u_scanner (
        .clk     (clk),
        .resetN  (resetN),
        .load    (load),
        .en      (en),
        .cx0     (ld_cx0),
        .cx1     (ld_cx1),
        .cy0     (ld_cy0),
        .cy1     (ld_cy1),
        .cx      (cx),
        .cy      (cy),
        .on_edge (on_edge),
        .last    (last)
    );

    always_comb begin
        state_d    = state_q;
        active_d   = 1'b0;
        done_d     = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        color_d    = color_q;
        scan_end_d = scan_end_q;
        load       = 1'b0;
        en         = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    load       = 1'b1;
                    scan_end_d = 1'b0;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                // scan_end_q marks that the last cell is already on the outputs.
                if (!scan_end_q) begin
                    active_d   = 1'b1;
                    x_d        = cx << S;
                    y_d        = cy << S;
                    color_d    = (ben_q && on_edge) ? border_q : fill_q;
                    en         = 1'b1;
                    scan_end_d = last;
                end else begin
                    done_d     = 1'b1;
                    scan_end_d = 1'b0;
                    state_d    = StRelease;
                end
            end
            StRelease: begin
                if (!write_awaited) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= StIdle;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            scan_end_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= '0;
            fill_q     <= '0;
            border_q   <= '0;
            ben_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            scan_end_q <= scan_end_d;
            x_q        <= x_d;
            y_q        <= y_d;
            color_q    <= color_d;
            if (load) begin
                fill_q   <= fill_color;
                border_q <= border_color;
                ben_q    <= border_en;
            end
        end
    end

    assign write_active     = active_q;
    assign write_x_addr     = x_q;
    assign write_y_addr     = y_q;
    assign write_color_data = color_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: doc/fb_rect_source.md
Name: fb_rect_source

Overview:
- A write source for the double-buffered frame manager, on the initiator side of its write-source handshake.
- When the manager signals `write_awaited` with `write_source_sel` equal to this block's ID, the block latches a rectangle description. It then streams one write per framebuffer cell, row-major, with `write_active` held high throughout.
- It then releases the bus so the manager can advance to the next source or swap frames.
- It clears or draws one rectangle per frame, for example a background fill or HUD box, on the manager's scaled grid.

Parameters:
- SOURCE_ID, 0, value of `write_source_sel` that grants this block the bus.
- SEL_W, 1, width of `write_source_sel`.
- DRAW_WIDTH, 640, screen width in pixels.
- DRAW_HEIGHT, 480, screen height in pixels.
- SCALE_DOWN_FACTOR, 2, pixels per cell edge (power of 2); S = $clog2(SCALE_DOWN_FACTOR).
- COLOR_DEPTH, 9, colour word width.

Ports:
- clk  in  1  single system clock.
- resetN  in  1  reset, synchronous and active-low.
- write_awaited  in  1  manager requests a write from the selected source.
- write_source_sel  in  SEL_W  currently selected source.
- rect_x  in  $clog2(DRAW_WIDTH)  left edge, in pixels.
- rect_y  in  $clog2(DRAW_HEIGHT)  top edge, in pixels.
- rect_w  in  $clog2(DRAW_WIDTH)  width, in pixels.
- rect_h  in  $clog2(DRAW_HEIGHT)  height, in pixels.
- fill_color  in  COLOR_DEPTH  interior colour.
- border_color  in  COLOR_DEPTH  edge-cell colour.
- border_en  in  1  draw the border using `border_color`.
- write_active  out  1  a write is valid this cycle.
- write_x_addr  out  $clog2(DRAW_WIDTH)  pixel x, always a multiple of SCALE_DOWN_FACTOR.
- write_y_addr  out  $clog2(DRAW_HEIGHT)  pixel y, always a multiple of SCALE_DOWN_FACTOR.
- write_color_data  out  COLOR_DEPTH  colour for this write.
- busy  out  1  a burst is in progress (WRITE or RELEASE state).
- done  out  1  one-cycle pulse when the burst ends.

Behaviour:
- Reset: synchronous on `resetN`==0 at a clk edge. All outputs go to 0 and the state goes to IDLE. Reset mid-burst drops `write_active` at that same edge, with no further writes.
- States:
  - IDLE: wait for `write_awaited`==1 and `write_source_sel`==SOURCE_ID. Then latch the inputs and compute cell bounds, and go to WRITE.
  - WRITE: emit one cell per cycle.
  - RELEASE: wait for `write_awaited`==0, then go to IDLE.
- RELEASE is mandatory. The manager clears `write_awaited` two cycles after it first sees `write_active`, so a short burst would otherwise re-trigger from IDLE.
- Cell bounds, computed at latch with widths one bit wider than the operands to avoid overflow:
  - cx0 = rect_x>>S
  - cy0 = rect_y>>S
  - cx1 = min(rect_x+max(rect_w,1)-1, DRAW_WIDTH-1)>>S
  - cy1 = min(rect_y+max(rect_h,1)-1, DRAW_HEIGHT-1)>>S
- Zero width or height is treated as 1, so at least one write is always emitted; the manager would hang if `write_active` never rose. A rect_x beyond the screen is clamped to cx0=cx1=(DRAW_WIDTH-1)>>S, and y likewise.
- Latency: `write_active` rises on the edge after the grant is sampled in IDLE. All write outputs are registered.
- Scan order: cy0..cy1 outer, cx0..cx1 inner, one cell per clk, no gaps. `write_active` stays high for exactly (cx1-cx0+1)*(cy1-cy0+1) consecutive cycles.
- Address outputs: write_x_addr = cx<<S and write_y_addr = cy<<S.
- Colour: `write_color_data` = `border_color` if `border_en` and the cell lies on cx0, cx1, cy0 or cy1; otherwise `fill_color`.
- End of burst: on the cycle after the last cell, `write_active` goes to 0, `done` pulses for one cycle and the state moves to RELEASE. The address outputs hold their last value.
- Inputs that change during WRITE have no effect; only latched values are used.
- While in RELEASE, `busy`=1 and `write_active`=0.

Decomposition:
- Package fb_pkg holds:
  - screen constants DRAW_WIDTH, DRAW_HEIGHT, SCALE_DOWN_FACTOR and COLOR_DEPTH;
  - the derived scaled width and height, and S;
  - the state enum {IDLE, WRITE, RELEASE}.
- Sub-module fb_cell_scanner is a loadable 2-D cell counter. It takes a load, cx0/cx1/cy0/cy1 and an enable. It outputs cx, cy, an on_edge flag and last.

Test Plan (640x480, SCALE 2, SOURCE_ID=0):
1. Grant with rect (10,20,8,6), border_en=1 -> 12 writes at cells x5..8, y10..12, starting at (10,20). Fill colour only at pixels (12,22) and (14,22); all other cells use the border colour. `done` pulses once.
2. rect (636,470,20,20) -> clipped to cells x318..319, y235..239. That gives 10 writes; the last is at (638,478).
3. rect_w=0, rect_h=0 at (100,100) -> exactly 1 write at (100,100) with fill colour. The block then holds in RELEASE until `write_awaited` falls, with no second burst.
4. `write_source_sel`=1 with `write_awaited`=1 -> `write_active` stays 0 indefinitely.
5. Drive `resetN` low on the 3rd cycle of a 12-cell burst -> `write_active`=0 at that edge. The block is in IDLE; the next grant produces a full 12-cell burst.
6. Change `fill_color` mid-burst -> every remaining write still uses the latched colour.
